// File: rtl/iter_div_unit_if.sv
// Request/response bundle between the EX-stage issue logic and the iterative divider.
interface iter_div_unit_if #(parameter int XLEN = 32);
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] A;
  logic [XLEN-1:0] B;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (output start, op, A, B, input busy, done, result);
  modport slave  (input start, op, A, B, output busy, done, result);
endinterface

// File: rtl/iter_div_unit.sv
// RV32M DIV/DIVU/REM/REMU unit: restoring shift-subtract, one quotient bit per clock.
// state | meaning
// IDLE  | waiting for start; operands captured on an accepted start
// CALC  | 32 shift-subtract iterations on magnitudes
// FIX   | sign correction and result load
// DONE  | one-cycle done strobe
module iter_div_unit #(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input logic           clk,
  input logic           rst,
  iter_div_unit_if.slave bus
);
  localparam int CNT_W = $clog2(ITER);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t          state, state_nxt;
  logic [XLEN-1:0] rem_r, quo_r, dvs_r, result_r;
  logic [CNT_W-1:0] cnt_r;
  logic            is_rem_r, neg_q_r, neg_r_r;

  logic            sgn_op, is_rem, b_zero, ovf, special;
  logic [XLEN-1:0] a_abs, b_abs, spec_res;
  logic [XLEN:0]   t, s;

  assign sgn_op  = ~bus.op[0];
  assign is_rem  = bus.op[1];
  assign b_zero  = (bus.B == '0);
  assign ovf     = sgn_op && (bus.A == {1'b1, {(XLEN-1){1'b0}}}) && (bus.B == '1);
  assign special = b_zero | ovf;
  assign a_abs   = (sgn_op && bus.A[XLEN-1]) ? (~bus.A + XLEN'(1)) : bus.A;
  assign b_abs   = (sgn_op && bus.B[XLEN-1]) ? (~bus.B + XLEN'(1)) : bus.B;

  always_comb begin
    spec_res = '0;
    if (b_zero)
      spec_res = is_rem ? bus.A : '1;
    else
      spec_res = is_rem ? '0 : {1'b1, {(XLEN-1){1'b0}}};
  end

  // The stored remainder stays below the divisor, so its 33rd bit is always
  // zero and only the low word needs to be kept.
  always_comb begin
    t = {rem_r, quo_r[XLEN-1]};
    s = t + ~{1'b0, dvs_r} + {{XLEN{1'b0}}, 1'b1};
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (bus.start) state_nxt = special ? S_DONE : S_CALC;
      S_CALC: if (cnt_r == '0) state_nxt = S_FIX;
      S_FIX:  state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_r    <= '0;
      quo_r    <= '0;
      dvs_r    <= '0;
      cnt_r    <= '0;
      result_r <= '0;
      is_rem_r <= 1'b0;
      neg_q_r  <= 1'b0;
      neg_r_r  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            if (special) begin
              result_r <= spec_res;
            end else begin
              rem_r    <= '0;
              quo_r    <= a_abs;
              dvs_r    <= b_abs;
              cnt_r    <= CNT_W'(ITER - 1);
              is_rem_r <= is_rem;
              neg_q_r  <= sgn_op & (bus.A[XLEN-1] ^ bus.B[XLEN-1]);
              neg_r_r  <= sgn_op & bus.A[XLEN-1];
            end
          end
        end
        S_CALC: begin
          cnt_r <= cnt_r - CNT_W'(1);
          if (!s[XLEN]) begin
            rem_r <= s[XLEN-1:0];
            quo_r <= {quo_r[XLEN-2:0], 1'b1};
          end else begin
            rem_r <= t[XLEN-1:0];
            quo_r <= {quo_r[XLEN-2:0], 1'b0};
          end
        end
        S_FIX: begin
          if (is_rem_r)
            result_r <= neg_r_r ? (~rem_r + XLEN'(1)) : rem_r;
          else
            result_r <= neg_q_r ? (~quo_r + XLEN'(1)) : quo_r;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy   = (state != S_IDLE);
  assign bus.done   = (state == S_DONE);
  assign bus.result = result_r;
endmodule

// File: tb/tb_iter_div_unit.sv
// Directed bench for iter_div_unit: stimulus pushes expectations, a negedge monitor pops on done.
module tb_iter_div_unit;
  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  iter_div_unit_if bus ();
  iter_div_unit dut (.clk(clk), .rst(rst), .bus(bus.slave));

  logic [31:0] res_q[$];
  int          lat_q[$];
  int          bsy_q[$];
  string       name_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int start_cyc = 0;
  int busy_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Latency is counted in rising edges from the start-capturing edge to the
  // edge that raised done; busy is counted in cycles seen high.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      busy_cnt = 0;
    end else begin
      if (bus.busy === 1'b1) busy_cnt++;
      if (bus.done === 1'b1) begin
        if (res_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: result=0x%08h with nothing outstanding", bus.result);
        end else begin
          string nm;
          nm = name_q.pop_front();
          chk({nm, "_result"}, bus.result, res_q.pop_front());
          chk({nm, "_done_edge"}, 32'(cyc - start_cyc), 32'(lat_q.pop_front()));
          chk({nm, "_busy_cycles"}, 32'(busy_cnt), 32'(bsy_q.pop_front()));
        end
        busy_cnt = 0;
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] res, input int lat, input int bsy,
                       input string nm, input bit push);
    @(negedge clk);
    bus.op = op;
    bus.A = a;
    bus.B = b;
    bus.start = 1'b1;
    if (push) begin
      res_q.push_back(res);
      lat_q.push_back(lat);
      bsy_q.push_back(bsy);
      name_q.push_back(nm);
    end
    @(posedge clk);
    #1;
    start_cyc = cyc;
    bus.start = 1'b0;
    bus.A = $urandom;
    bus.B = $urandom;
    bus.op = 2'($urandom);
  endtask

  task automatic wait_done(input string nm);
    int t;
    t = 0;
    while (res_q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (res_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: %0d results still outstanding after %0d cycles", nm, res_q.size(), t);
      res_q.delete();
      lat_q.delete();
      bsy_q.delete();
      name_q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] res, input bit spec, input string nm);
    issue(op, a, b, res, spec ? 0 : 33, spec ? 1 : 34, nm, 1'b1);
    wait_done(nm);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.op = 2'b00;
    bus.A = '0;
    bus.B = '0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_busy", {31'd0, bus.busy}, 32'd0);
    chk("reset_done", {31'd0, bus.done}, 32'd0);
    chk("reset_result", bus.result, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run(OP_DIVU, 32'd100,       32'd7,          32'd14,         1'b0, "divu_100_7");
    run(OP_REMU, 32'd100,       32'd7,          32'd2,          1'b0, "remu_100_7");
    run(OP_DIV,  32'hFFFFFFF9,  32'd2,          32'hFFFFFFFD,   1'b0, "div_m7_2");
    run(OP_REM,  32'hFFFFFFF9,  32'd2,          32'hFFFFFFFF,   1'b0, "rem_m7_2");
    run(OP_DIV,  32'd7,         32'hFFFFFFFE,   32'hFFFFFFFD,   1'b0, "div_7_m2");
    run(OP_DIVU, 32'h80000000,  32'hFFFFFFFF,   32'd0,          1'b0, "divu_min_max");
    run(OP_REMU, 32'h80000000,  32'hFFFFFFFF,   32'h80000000,   1'b0, "remu_min_max");
    run(OP_DIVU, 32'd5,         32'd0,          32'hFFFFFFFF,   1'b1, "divu_by0");
    run(OP_REMU, 32'd5,         32'd0,          32'd5,          1'b1, "remu_by0");
    run(OP_DIV,  32'hFFFFFFF9,  32'd0,          32'hFFFFFFFF,   1'b1, "div_by0");
    run(OP_DIV,  32'h80000000,  32'hFFFFFFFF,   32'h80000000,   1'b1, "div_ovf");
    run(OP_REM,  32'h80000000,  32'hFFFFFFFF,   32'd0,          1'b1, "rem_ovf");

    // A start pulse in the middle of CALC must neither restart nor re-capture.
    issue(OP_REMU, 32'hFFFFFFFF, 32'h10, 32'hF, 33, 34, "remu_ignored_start", 1'b1);
    repeat (10) @(negedge clk);
    bus.op = OP_DIVU;
    bus.A = 32'd100;
    bus.B = 32'd7;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("remu_ignored_start");
    repeat (40) @(negedge clk);

    // Asynchronous abort mid-calculation.
    issue(OP_DIVU, 32'd1000, 32'd3, 32'd0, 0, 0, "divu_abort", 1'b0);
    repeat (10) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_done", {31'd0, bus.done}, 32'd0);
    chk("abort_result", bus.result, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    run(OP_DIVU, 32'd9, 32'd3, 32'd3, 1'b0, "divu_after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/iter_div_unit.md
Name: iter_div_unit

Overview:
- Multi-cycle RV32M divide/remainder unit in the EX stage, beside the 32-bit add/sub ALU.
- Implements the shift-subtract iteration by driving its own 33-bit subtract path (A + ~B + carry-in 1), one iteration per clock.
- Accepts a start pulse with operands and returns one 32-bit result with a single-cycle done strobe.
- Stalls the pipeline via busy.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- ITER, 32, iterations per operation; must equal XLEN.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- op  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- A  input  32  dividend; captured on accepted start.
- B  input  32  divisor; captured on accepted start.
- busy  output  1  high in every state except IDLE.
- done  output  1  single-cycle strobe; high only in DONE.
- result  output  32  quotient or remainder; registered; held until the next accepted start.

Behaviour:
- Reset:
  - one clock; reset is asynchronous and active-high.
  - On rst: state=IDLE, busy=0, done=0, result=0, all internal registers cleared.
  - Applies immediately, including mid-operation; no partial result is produced.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - start=1 at edge E0 captures op, A, B.
  - Special case → DONE at E0, result loaded at E0 (done visible the cycle after the start edge).
  - Otherwise → CALC at E0.
  - start=0 → stay in IDLE.
- Special cases:
  - B=0: quotient=0xFFFFFFFF; remainder=A.
  - Signed overflow (op DIV/REM, A=0x80000000, B=0xFFFFFFFF): quotient=0x80000000; remainder=0.
- CALC:
  - On entry: R(33b)=0; Q=|A|; D=|B|.
  - |x| is applied only for DIV/REM with x[31]=1; unsigned ops use raw values.
  - Each edge:
    - T={R[31:0],Q[31]}
    - S=T+~{0,D}+1 (33-bit)
    - if S[32]=0: R=S, Q={Q[30:0],1}
    - else: R=T, Q={Q[30:0],0}
  - A 5-bit iteration counter runs 0..31; after the 32nd iteration (edge E32) → FIX.
- FIX (one edge, E33):
  - DIV: result = Q, negated if A[31]^B[31].
  - REM: result = R[31:0], negated if A[31].
  - DIVU/REMU: result uncorrected.
  - → DONE.
- DONE:
  - done=1 for exactly one cycle (between E33 and E34); → IDLE at next edge.
- Latency:
  - normal op: done high 33 cycles after the start edge; busy high 34 cycles.
  - special case: done high 1 cycle after the start edge; busy 1 cycle.
- start while busy (CALC/FIX/DONE): ignored, not queued; operands are not re-captured.
- Operand inputs may change after an accepted start without effect.
- Arithmetic is two's complement modulo 2^32; negation = ~x+1.
- No X propagation: all outputs are driven from registers or state decode.

Test Plan:
- DIVU A=100, B=7 → result=14; done exactly 33 cycles after start edge; busy high 34 cycles; REMU same operands → 2.
- DIV A=0xFFFFFFF9 (-7), B=2 → 0xFFFFFFFD (-3); REM same → 0xFFFFFFFF (-1); DIV A=7, B=0xFFFFFFFE → 0xFFFFFFFD.
- DIVU A=5, B=0 → 0xFFFFFFFF; REMU A=5, B=0 → 5; DIV A=0xFFFFFFF9, B=0 → 0xFFFFFFFF; each returns done 1 cycle after start.
- DIV A=0x80000000, B=0xFFFFFFFF → 0x80000000; REM same → 0; done after 1 cycle.
- REMU A=0xFFFFFFFF, B=0x10 → 0xF; then pulse start with new operands at iteration 10 → ignored, result still 0xF.
- Start DIVU 1000/3; assert rst asynchronously mid-cycle at iteration 10 → busy, done, result drop to 0 immediately. Release rst, start DIVU 9/3 → result=3 after 33 cycles.
